// File: rtl/error_line_buffer_pkg.sv
// error_line_buffer_pkg
// Shared constants and the FSM state encoding for the error-diffusion line
// buffer. The localparams are the default geometry; the top module exposes
// them as overridable parameters.
package error_line_buffer_pkg;

  localparam int ELB_ERROR_BITS = 9;     // signed error, 10p1 as the kernel emits it
  localparam int ELB_MAX_WIDTH  = 1024;  // pixels per line == RAM depth
  localparam int ELB_ADDR_BITS  = $clog2(ELB_MAX_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } elb_state_e;

endpackage

// File: rtl/error_line_ram.sv
// error_line_ram
// Simple dual-port RAM holding one line of finalised errors.
// Read is registered with a single cycle of latency; when i_rd_en is low the
// output register holds its previous value so the consumer can stall freely.
// The write port is fully independent of the read port.
//
// Ports:
//   clk        clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe (output holds while low)
//   i_rd_addr  read address
//   o_rd_data  registered read data
module error_line_ram #(
  parameter int DATA_BITS = 9,
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] r_rd_data;

  // No reset: keeps the array and its output register mappable to block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/error_line_buffer.sv
// error_line_buffer
// Owns all inter-line error state of the error-diffusion dither path.
// While a line streams through the kernel it stores each column's finalised
// error (err_bottom_left_out, which refers to column x-1) into the line RAM,
// and it registers the kernel's partial errors for columns x and x+1 so they
// come back as inputs for the next pixel. On the following line it replays
// the stored errors, one column per pixel, in lockstep with the stream.
//
// Handshake: ready is high exactly while the FSM is ACTIVE. A pixel is
// consumed on a rising edge where pix_valid && ready (and frame_start is
// low); pix_last is only meaningful alongside such a pixel. Outputs to the
// kernel describe the column of the pixel being offered and hold while
// pix_valid is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_start              pulse: abort any line, next line is first of frame
//   line_start               pulse: begin a line (honoured only in IDLE)
//   pix_valid, pix_last      pixel consumed this cycle / it ends the line
//   ready                    block accepts pix_valid this cycle
//   err_bottom_left_out      kernel: finalised error for column x-1
//   err_bottom_out           kernel: partial error for column x
//   err_bottom_right_out     kernel: partial error for column x+1
//   err_line_buffer_in       to kernel: stored error of the previous line, column x
//   err_bottom_left_in       to kernel: err_bottom_out of pixel x-1
//   err_bottom_in            to kernel: err_bottom_right_out of pixel x-1
//   overrun                  sticky: a line ran past MAX_WIDTH; cleared by frame_start
//   o_dbg_state              current FSM state (elb_state_e encoding)
module error_line_buffer
  import error_line_buffer_pkg::*;
#(
  parameter int ERROR_BITS = ELB_ERROR_BITS,
  parameter int MAX_WIDTH  = ELB_MAX_WIDTH,
  parameter int ADDR_BITS  = ELB_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  pix_valid,
  input  logic                  pix_last,
  output logic                  ready,
  input  logic [ERROR_BITS-1:0] err_bottom_left_out,
  input  logic [ERROR_BITS-1:0] err_bottom_out,
  input  logic [ERROR_BITS-1:0] err_bottom_right_out,
  output logic [ERROR_BITS-1:0] err_line_buffer_in,
  output logic [ERROR_BITS-1:0] err_bottom_left_in,
  output logic [ERROR_BITS-1:0] err_bottom_in,
  output logic                  overrun,
  output logic [1:0]            o_dbg_state
);

  localparam logic [ADDR_BITS-1:0] ONE      = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(MAX_WIDTH - 1);

  elb_state_e            r_state;
  logic [ADDR_BITS-1:0]  r_col;        // column of the next pixel, saturates at LAST_COL
  logic                  r_full;       // a pixel at LAST_COL was consumed this line
  logic                  r_line_over;  // this line ran beyond LAST_COL
  logic                  r_first_line;
  logic                  r_overrun;
  logic [ERROR_BITS-1:0] r_bl;
  logic [ERROR_BITS-1:0] r_b;

  logic                  w_wr_en;
  logic [ADDR_BITS-1:0]  w_wr_addr;
  logic [ERROR_BITS-1:0] w_wr_data;
  logic                  w_rd_en;
  logic [ADDR_BITS-1:0]  w_rd_addr;
  logic [ERROR_BITS-1:0] w_rd_data;

  // RAM port control. Within a line the read (col+1) always leads the write
  // (col-1), so the two ports never touch the same address in one cycle.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_col - ONE;
    w_wr_data = err_bottom_left_out;
    w_rd_en   = 1'b0;
    w_rd_addr = r_col + ONE;
    if (frame_start) begin
      // Abort: never write; a simultaneous line_start still primes column 0.
      if (line_start) begin
        w_rd_en   = 1'b1;
        w_rd_addr = '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (line_start) begin
            w_rd_en   = 1'b1;
            w_rd_addr = '0;
          end
        end
        ST_ACTIVE: begin
          if (pix_valid) begin
            w_rd_en = 1'b1;
            // Column 0's left error falls off the left edge; once the line
            // is past the last RAM column the write has nowhere to go.
            w_wr_en = (r_col != '0) && !r_full;
          end
        end
        ST_FLUSH: begin
          // The last pixel's bottom error is now final for its own column.
          // When the line filled the RAM exactly, that column is LAST_COL.
          w_wr_en   = !r_line_over;
          w_wr_data = r_bl;
          w_wr_addr = r_full ? r_col : (r_col - ONE);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_full       <= 1'b0;
      r_line_over  <= 1'b0;
      r_first_line <= 1'b1;
      r_overrun    <= 1'b0;
      r_bl         <= '0;
      r_b          <= '0;
    end else if (frame_start) begin
      r_first_line <= 1'b1;
      r_overrun    <= 1'b0;
      r_col        <= '0;
      r_full       <= 1'b0;
      r_line_over  <= 1'b0;
      r_bl         <= '0;
      r_b          <= '0;
      r_state      <= line_start ? ST_ACTIVE : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (line_start) begin
            r_col       <= '0;
            r_full      <= 1'b0;
            r_line_over <= 1'b0;
            r_bl        <= '0;
            r_b         <= '0;
            r_state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (pix_valid) begin
            r_bl <= err_bottom_out;
            r_b  <= err_bottom_right_out;
            if (r_full) begin
              r_line_over <= 1'b1;
              r_overrun   <= 1'b1;
            end
            if (r_col == LAST_COL) begin
              r_full <= 1'b1;
            end else begin
              r_col <= r_col + ONE;
            end
            if (pix_last) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          r_first_line <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  error_line_ram #(
    .DATA_BITS (ERROR_BITS),
    .DEPTH     (MAX_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // The first line of a frame has no line above it, whatever the RAM holds.
  assign err_line_buffer_in = r_first_line ? '0 : w_rd_data;
  assign err_bottom_left_in = r_bl;
  assign err_bottom_in      = r_b;
  assign ready              = (r_state == ST_ACTIVE);
  assign overrun            = r_overrun;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_error_line_buffer.sv
module tb_error_line_buffer;
  import error_line_buffer_pkg::*;

  localparam int EB = 9;
  localparam int MW = 8;
  localparam int AB = 3;
  localparam int QW = 1 + 3 * EB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          frame_start, line_start, pix_valid, pix_last;
  logic          ready, overrun;
  logic [1:0]    dbg_state;
  logic [EB-1:0] bl_out, b_out, br_out;
  logic [EB-1:0] lb_in, bl_in, b_in;

  error_line_buffer #(.ERROR_BITS(EB), .MAX_WIDTH(MW), .ADDR_BITS(AB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .frame_start          (frame_start),
    .line_start           (line_start),
    .pix_valid            (pix_valid),
    .pix_last             (pix_last),
    .ready                (ready),
    .err_bottom_left_out  (bl_out),
    .err_bottom_out       (b_out),
    .err_bottom_right_out (br_out),
    .err_line_buffer_in   (lb_in),
    .err_bottom_left_in   (bl_in),
    .err_bottom_in        (b_in),
    .overrun              (overrun),
    .o_dbg_state          (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Stored line: what column c of the previous line finalised to, if known.
  logic [EB-1:0] m_mem [MW];
  bit            m_known [MW];
  bit            m_first;
  bit            m_over;

  // ---------------- scoreboard ----------------
  // entry = {check_line_buffer, line_buffer, bottom_left_in, bottom_in}
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pixel the kernel presents while ready is compared with
  // the oldest expectation.
  always @(negedge clk) begin
    if (!rst && pix_valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: pixel taken with no expectation at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[QW-1]) check("line_buffer_in", 32'(lb_in), 32'(mon_e[3*EB-1:2*EB]));
        check("bottom_left_in", 32'(bl_in), 32'(mon_e[2*EB-1:EB]));
        check("bottom_in", 32'(b_in), 32'(mon_e[EB-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: random data; mode 1: bottom=k+1, left=10+k, right=0.
  // neg5: pixel 0 bottom-right error forced to -5.
  // stall_at: three idle cycles before that pixel; stall_max: random idles.
  // abort_at: frame_start replaces that pixel, ending the line.
  task automatic run_line(input int n, input bit fs, input int mode, input bit neg5,
                          input int stall_at, input int stall_max, input int abort_at);
    logic [EB-1:0] bo [16];
    logic [EB-1:0] bl [16];
    logic [EB-1:0] br [16];
    logic [EB-1:0] lb_exp [16];
    bit            lb_chk [16];
    logic [EB-1:0] e_bl, e_b;
    int            st;
    for (int k = 0; k < n; k++) begin
      if (mode == 1) begin
        bo[k] = EB'(k + 1);
        bl[k] = EB'(10 + k);
        br[k] = '0;
      end else begin
        bo[k] = EB'($urandom_range(0, 511));
        bl[k] = EB'($urandom_range(0, 511));
        br[k] = EB'($urandom_range(0, 511));
      end
    end
    if (neg5) br[0] = 9'h1FB;

    @(posedge clk); #1;
    line_start  = 1'b1;
    frame_start = fs;
    if (fs) begin
      m_first = 1'b1;
      m_over  = 1'b0;
    end
    @(posedge clk); #1;
    line_start  = 1'b0;
    frame_start = 1'b0;

    // What this line must read back is fixed before any of its own writes.
    for (int k = 0; k < n; k++) begin
      if (m_first) begin
        lb_chk[k] = 1'b1;
        lb_exp[k] = '0;
      end else if (k < MW && m_known[k]) begin
        lb_chk[k] = 1'b1;
        lb_exp[k] = m_mem[k];
      end else begin
        lb_chk[k] = 1'b0;
        lb_exp[k] = '0;
      end
    end

    for (int k = 0; k < n; k++) begin
      st = (k == stall_at) ? 3 : ((stall_max > 0) ? $urandom_range(0, stall_max) : 0);
      for (int s = 0; s < st; s++) begin
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        if (lb_chk[k]) check("stall_hold", 32'(lb_in), 32'(lb_exp[k]));
        @(posedge clk); #1;
      end
      if (k == abort_at) begin
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        m_first = 1'b1;
        m_over  = 1'b0;
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_bl_in", 32'(bl_in), 32'd0);
        check("abort_b_in", 32'(b_in), 32'd0);
        check("abort_lb_in", 32'(lb_in), 32'd0);
        return;
      end
      check("ready_pix", 32'(ready), 32'd1);
      e_bl = (k == 0) ? '0 : bo[k-1];
      e_b  = (k == 0) ? '0 : br[k-1];
      exp_q.push_back({lb_chk[k], lb_exp[k], e_bl, e_b});
      pix_valid = 1'b1;
      pix_last  = (k == n - 1);
      bl_out    = bl[k];
      b_out     = bo[k];
      br_out    = br[k];
      @(posedge clk); #1;
      // Pixel k finalises column k-1; columns past the RAM are lost.
      if (k >= 1 && k - 1 <= MW - 2) begin
        m_mem[k-1]   = bl[k];
        m_known[k-1] = 1'b1;
      end
      if (k >= MW) m_over = 1'b1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    check("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
    check("flush_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    if (n <= MW) begin
      m_mem[n-1]   = bo[n-1];
      m_known[n-1] = 1'b1;
    end
    m_first = 1'b0;
    check("end_state", 32'(dbg_state), 32'(ST_IDLE));
    check("end_ready", 32'(ready), 32'd0);
    check("end_overrun", 32'(overrun), 32'(m_over));
  endtask

  task automatic pulse_frame_start();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_first = 1'b1;
    m_over  = 1'b0;
    check("fs_state", 32'(dbg_state), 32'(ST_IDLE));
    check("fs_overrun", 32'(overrun), 32'd0);
  endtask

  task automatic reset_mid_line();
    @(posedge clk); #1;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    check("pre_reset_ready", 32'(ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_lb_in", 32'(lb_in), 32'd0);
    check("rst_bl_in", 32'(bl_in), 32'd0);
    check("rst_b_in", 32'(b_in), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_first = 1'b1;
    m_over  = 1'b0;
    for (int c = 0; c < MW; c++) m_known[c] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, ab;
    rst = 1'b1;
    frame_start = 1'b0; line_start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
    bl_out = '0; b_out = '0; br_out = '0;
    m_first = 1'b1;
    m_over  = 1'b0;
    for (int c = 0; c < MW; c++) begin
      m_known[c] = 1'b0;
      m_mem[c]   = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_lb_in", 32'(lb_in), 32'd0);
    check("reset_bl_in", 32'(bl_in), 32'd0);
    check("reset_b_in", 32'(b_in), 32'd0);

    // First line of a frame, fixed pattern; replayed twice, once with a stall.
    run_line(4, 1'b1, 1, 1'b0, -1, 0, -1);
    run_line(4, 1'b0, 1, 1'b0, -1, 0, -1);
    run_line(4, 1'b0, 1, 1'b0, 2, 0, -1);
    // Negative right error carried into the next pixel.
    run_line(5, 1'b1, 0, 1'b1, -1, 0, -1);
    run_line(5, 1'b0, 0, 1'b0, -1, 0, -1);
    // Exactly full line, then an overrunning line, then read back.
    run_line(8, 1'b0, 0, 1'b0, -1, 0, -1);
    run_line(10, 1'b0, 0, 1'b0, -1, 0, -1);
    run_line(8, 1'b0, 0, 1'b0, -1, 1, -1);
    pulse_frame_start();
    // Abort mid-line, then the next line reads zeros.
    run_line(6, 1'b0, 0, 1'b0, -1, 0, 2);
    run_line(6, 1'b0, 0, 1'b0, -1, 0, -1);
    run_line(7, 1'b0, 0, 1'b0, -1, 1, -1);

    for (int i = 0; i < 40; i++) begin
      n  = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 10) : $urandom_range(1, 8);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
      run_line(n, ($urandom_range(0, 5) == 0), 0, 1'b0, -1, 2, ab);
    end

    // Leave overrun set, then reset in the middle of a line.
    run_line(9, 1'b0, 0, 1'b0, -1, 0, -1);
    reset_mid_line();
    run_line(6, 1'b0, 0, 1'b0, -1, 1, -1);
    run_line(6, 1'b0, 0, 1'b0, -1, 1, -1);

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: %0d pixels expected but not taken", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
